m2vvld_arb: RTL and testbench

M2VVLD_ARB -- requirements
Module: m2vvld_arb

---
 rtl/m2vvld_arb_if.sv | 34 +++
 rtl/m2vvld_arb.sv | 162 ++++++++++++++++
 tb/tb_m2vvld_arb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/m2vvld_arb_if.sv
// Requester, response and VLD-side signals of the m2vvld_arb decode arbiter.
// The arbiter uses the slave modport; the requester/VLD side uses master.
interface m2vvld_arb_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [2:0]  req0_table;
  logic [2:0]  req1_table;
  logic        req0_ready;
  logic        req1_ready;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [13:0] rsp_data;
  logic        rsp_nextbit;
  logic [2:0]  vld_table;
  logic        vld_decode;
  logic [13:0] symbol_data;
  logic        symbol_valid;
  logic        symbol_nextbit;
  logic        err_timeout;

  modport master (
    output req0_valid, req1_valid, req0_table, req1_table,
    output symbol_data, symbol_valid, symbol_nextbit,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_nextbit, vld_table, vld_decode, err_timeout
  );

  modport slave (
    input  req0_valid, req1_valid, req0_table, req1_table,
    input  symbol_data, symbol_valid, symbol_nextbit,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_nextbit, vld_table, vld_decode, err_timeout
  );
endinterface

// File: rtl/m2vvld_arb.sv
// Round-robin front end sharing one VLD decoder between two requesters, one decode
// in flight. Define M2VVLD_ARB_WATCHDOG_EN to abort a BUSY decode after TIMEOUT_CYCLES.
module m2vvld_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         reset,
  m2vvld_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_owner_r;
  logic        owner_r;
  logic [2:0]  table_r;
  logic        vld_decode_r;
  logic        rsp0_valid_r;
  logic        rsp1_valid_r;
  logic [13:0] rsp_data_r;
  logic        rsp_nextbit_r;

  logic        accept_s;
  logic        winner_s;
  logic        rsp_fire_s;
  logic [13:0] rsp_data_nxt_s;
  logic        rsp_nextbit_nxt_s;

`ifdef M2VVLD_ARB_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt_r;
  logic             err_timeout_r;
  logic             expire_s;
  logic             timeout_s;

  // Counts BUSY cycles; cleared while the decode is being issued
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ISSUE) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == BUSY) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign expire_s = (state_r == BUSY) && (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // Sticky abort flag, only cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout_r <= 1'b0;
    end else if (timeout_s) begin
      err_timeout_r <= 1'b1;
    end else begin
      err_timeout_r <= err_timeout_r;
    end
  end

  assign bus.err_timeout = err_timeout_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign bus.err_timeout  = 1'b0;
`endif

  // Next state, arbitration and response selection
  always_comb begin
    state_nxt_s       = state_r;
    accept_s          = 1'b0;
    winner_s          = 1'b0;
    rsp_fire_s        = 1'b0;
    rsp_data_nxt_s    = 14'h0000;
    rsp_nextbit_nxt_s = 1'b0;
`ifdef M2VVLD_ARB_WATCHDOG_EN
    timeout_s         = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        // ready is combinational on valid, so it is held off while reset is applied
        if (!reset && (bus.req0_valid || bus.req1_valid)) begin
          accept_s    = 1'b1;
          winner_s    = (bus.req0_valid && bus.req1_valid) ? ~last_owner_r : bus.req1_valid;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = BUSY;
      end
      BUSY: begin
        if (bus.symbol_valid) begin
          rsp_fire_s        = 1'b1;
          rsp_data_nxt_s    = bus.symbol_data;
          rsp_nextbit_nxt_s = bus.symbol_nextbit;
          state_nxt_s       = IDLE;
        end
`ifdef M2VVLD_ARB_WATCHDOG_EN
        else if (expire_s) begin
          rsp_fire_s  = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end
`endif
        else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched transaction and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_owner_r  <= 1'b1;
      owner_r       <= 1'b0;
      table_r       <= 3'd0;
      vld_decode_r  <= 1'b0;
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp_data_r    <= 14'h0000;
      rsp_nextbit_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      vld_decode_r <= accept_s;
      rsp0_valid_r <= rsp_fire_s && !owner_r;
      rsp1_valid_r <= rsp_fire_s && owner_r;
      if (accept_s) begin
        last_owner_r <= winner_s;
        owner_r      <= winner_s;
        table_r      <= winner_s ? bus.req1_table : bus.req0_table;
      end
      if (rsp_fire_s) begin
        rsp_data_r    <= rsp_data_nxt_s;
        rsp_nextbit_r <= rsp_nextbit_nxt_s;
      end
    end
  end

  assign bus.req0_ready  = accept_s && !winner_s;
  assign bus.req1_ready  = accept_s && winner_s;
  assign bus.vld_decode  = vld_decode_r;
  assign bus.vld_table   = table_r;
  assign bus.rsp0_valid  = rsp0_valid_r;
  assign bus.rsp1_valid  = rsp1_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.rsp_nextbit = rsp_nextbit_r;

endmodule

// File: tb/tb_m2vvld_arb.sv
// Bench for m2vvld_arb: directed scenarios then random traffic, every cycle checked
// against a transaction-timing reference model. Honours M2VVLD_ARB_WATCHDOG_EN.
module tb_m2vvld_arb;
  localparam int TMO = 16;
`ifdef M2VVLD_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  m2vvld_arb_if bus();
  m2vvld_arb #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int n = 0;

  // stimulus knobs
  bit          rst_k, r0v, r1v, man_sv, man_nb, rnd_sym;
  logic [2:0]  r0t, r1t;
  logic [13:0] man_sd;
  int          lat;

  // reference model: a transaction is described by the cycle it was accepted in
  bit          m_idle, m_owner, m_last, m_err, m_nb;
  logic [2:0]  m_table;
  logic [13:0] m_data;
  int          m_t, m_dec, m_rsp;

  // observed events
  bit          grants[$];
  logic [2:0]  tables[$];
  int          rsp_count = 0;
  int          base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_last = 1'b1; m_owner = 1'b0; m_table = 3'd0;
    m_data = 14'h0000; m_nb = 1'b0; m_err = 1'b0; m_dec = -1; m_rsp = -1; m_t = 0;
  endtask

  // One clock: drive inputs, check every output, then advance the model past the edge
  task automatic cyc();
    bit sv, snb, win, acc;
    logic [13:0] sd;
    @(posedge clk); #1;
    sv  = man_sv;
    sd  = rnd_sym ? 14'($urandom) : man_sd;
    snb = rnd_sym ? 1'($urandom) : man_nb;
    if (lat > 0 && m_dec >= 0 && n == m_dec + lat) sv = 1'b1;
    reset              = rst_k;
    bus.req0_valid     = r0v;
    bus.req0_table     = r0t;
    bus.req1_valid     = r1v;
    bus.req1_table     = r1t;
    bus.symbol_valid   = sv;
    bus.symbol_data    = sd;
    bus.symbol_nextbit = snb;
    #1;
    acc = !rst_k && m_idle && (r0v || r1v);
    win = (r0v && r1v) ? ~m_last : r1v;
    chk("req0_ready",  bus.req0_ready,  acc && !win);
    chk("req1_ready",  bus.req1_ready,  acc && win);
    chk("vld_decode",  bus.vld_decode,  n == m_dec);
    chk("vld_table",   bus.vld_table,   m_table);
    chk("rsp0_valid",  bus.rsp0_valid,  (n == m_rsp) && !m_owner);
    chk("rsp1_valid",  bus.rsp1_valid,  (n == m_rsp) && m_owner);
    chk("rsp_data",    bus.rsp_data,    m_data);
    chk("rsp_nextbit", bus.rsp_nextbit, m_nb);
    chk("err_timeout", bus.err_timeout, m_err);
    if (bus.req0_ready) grants.push_back(1'b0);
    if (bus.req1_ready) grants.push_back(1'b1);
    if (bus.vld_decode) tables.push_back(bus.vld_table);
    if (bus.rsp0_valid || bus.rsp1_valid) rsp_count++;
    if (rst_k) begin
      model_reset();
    end else if (acc) begin
      m_idle = 1'b0; m_t = n; m_owner = win; m_last = win;
      m_table = win ? r1t : r0t; m_dec = n + 1;
      if (rnd_sym) lat = $urandom_range(1, 4);
    end else if (!m_idle && n >= m_t + 2) begin
      if (sv) begin
        m_rsp = n + 1; m_data = sd; m_nb = snb; m_idle = 1'b1;
      end else if (WD && n == m_t + 1 + TMO) begin
        m_rsp = n + 1; m_data = 14'h0000; m_nb = 1'b0; m_err = 1'b1; m_idle = 1'b1;
      end
    end
    n++;
  endtask

  initial begin
    bit          exp_g[4];
    logic [2:0]  exp_t[4];
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_t = '{3'd1, 3'd7, 3'd1, 3'd7};
    rst_k = 1'b1; r0v = 1'b0; r1v = 1'b0; r0t = 3'd0; r1t = 3'd0;
    man_sv = 1'b0; man_sd = 14'h0000; man_nb = 1'b0; lat = 0; rnd_sym = 1'b0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req0_table = 3'd0; bus.req1_table = 3'd0;
    bus.symbol_valid = 1'b0; bus.symbol_data = 14'h0000; bus.symbol_nextbit = 1'b0;
    model_reset();
    cyc();
    cyc();

    // single request, VLD answers three cycles after the decode
    rst_k = 1'b0; lat = 3; man_sd = 14'h1234; man_nb = 1'b1;
    r0v = 1'b1; r0t = 3'd6;
    cyc();
    r0v = 1'b0;
    repeat (6) cyc();
    chk("r29_grant", grants.size(), 1);
    chk("r29_table", tables.size() == 1 ? tables[0] : 3'bxxx, 3'd6);
    chk("r29_data", bus.rsp_data, 14'h1234);
    chk("r29_nextbit", bus.rsp_nextbit, 1'b1);

    // both requests held high from reset: round robin
    grants.delete(); tables.delete();
    rst_k = 1'b1; r0v = 1'b1; r1v = 1'b1; r0t = 3'd1; r1t = 3'd7; lat = 2; man_sd = 14'h2A5C;
    cyc();
    rst_k = 1'b0;
    repeat (14) cyc();
    r0v = 1'b0; r1v = 1'b0;
    repeat (4) cyc();
    chk("r30_ngrant", grants.size(), 4);
    chk("r30_ntable", tables.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("r30_grant", grants[i], exp_g[i]);
      if (i < tables.size()) chk("r30_table", tables[i], exp_t[i]);
    end

    // stray symbol while idle; table change after accept
    base = rsp_count;
    man_sv = 1'b1; man_sd = 14'h3FFF;
    cyc();
    man_sv = 1'b0; man_sd = 14'h0ABC;
    cyc();
    chk("r31_stray", rsp_count - base, 0);
    r1v = 1'b1; r1t = 3'd2; lat = 2;
    cyc();
    r1v = 1'b0; r1t = 3'd5;
    cyc();
    chk("r31_table_dec", bus.vld_table, 3'd2);
    cyc();
    chk("r31_table_busy", bus.vld_table, 3'd2);
    repeat (3) cyc();
    chk("r31_rsp", rsp_count - base, 1);

    // reset while BUSY, then symbol on the first cycle out of reset
    grants.delete();
    base = rsp_count; lat = 0;
    r0v = 1'b1; r0t = 3'd3;
    cyc();
    r0v = 1'b0;
    cyc();
    cyc();
    rst_k = 1'b1;
    cyc();
    rst_k = 1'b0; man_sv = 1'b1; man_sd = 14'h1111;
    cyc();
    man_sv = 1'b0;
    cyc();
    chk("r32_norsp", rsp_count - base, 0);
    chk("r32_data0", bus.rsp_data, 14'h0000);
    chk("r32_table0", bus.vld_table, 3'd0);
    r0v = 1'b1; r1v = 1'b1; r0t = 3'd5; r1t = 3'd6; lat = 2; man_sd = 14'h0F0F;
    cyc();
    chk("r32_tie", grants.size() > 0 ? grants[grants.size() - 1] : 1'bx, 1'b0);
    r0v = 1'b0; r1v = 1'b0;
    repeat (4) cyc();

    // VLD never answers
    base = rsp_count; lat = 0;
    r1v = 1'b1; r1t = 3'd4;
    cyc();
    r1v = 1'b0;
    repeat (TMO + 3) cyc();
    chk("r33_err", bus.err_timeout, WD);
    chk("r33_rsp", rsp_count - base, WD ? 1 : 0);
    repeat (3) cyc();
    chk("r33_sticky", bus.err_timeout, WD);
    rst_k = 1'b1;
    cyc();
    rst_k = 1'b0;
    cyc();
    chk("r33_cleared", bus.err_timeout, 1'b0);

    // random traffic, stray symbols and occasional reset
    rnd_sym = 1'b1; lat = $urandom_range(1, 4);
    repeat (400) begin
      rst_k  = ($urandom_range(0, 99) == 0);
      r0v    = 1'($urandom);
      r1v    = 1'($urandom);
      r0t    = 3'($urandom);
      r1t    = 3'($urandom);
      man_sv = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rst_k = 1'b0; r0v = 1'b0; r1v = 1'b0; man_sv = 1'b0;
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
